// File: rtl/trail_rect_writer_pkg.sv
// trail_rect_writer_pkg: shared screen geometry, field widths, FSM state
// encoding and an address range helper. It is used by the rectangle writer,
// its address walker and the interface.
package trail_rect_writer_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned MAX_ADDR = SCREEN_W * SCREEN_H - 1;  // 307199
  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned DIM_W    = 10;
  localparam int unsigned DATA_W   = 8;

  // This encoding is also used by the trail checker and by the game FSM.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

  // Returns 1 when a zero-extended linear address lies inside the frame.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] max_addr);
    return (addr <= max_addr);
  endfunction

endpackage

// File: rtl/trail_rect_writer_if.sv
// trail_rect_writer_if: groups the request side (from game FSM) and the
// memory write side (to trail arbiter) of the rectangle writer.
//   slave  : the writer itself (takes requests, drives memory writes)
//   master : environment (issues requests, grants wr_ready)
interface trail_rect_writer_if
  import trail_rect_writer_pkg::*;
#(
  parameter int unsigned P_ADDR_W = ADDR_W,
  parameter int unsigned P_DIM_W  = DIM_W,
  parameter int unsigned P_DATA_W = DATA_W
);
  logic                start;
  logic                abort;
  logic [P_DIM_W-1:0]  x_len;
  logic [P_DIM_W-1:0]  y_len;
  logic [P_ADDR_W-1:0] start_addr;
  logic [P_DATA_W-1:0] color;
  logic                wr_ready;
  logic                wr_en;
  logic [P_ADDR_W-1:0] wr_addr;
  logic [P_DATA_W-1:0] wr_data;
  logic                busy;
  logic                done;

  modport slave (
    input  start, abort, x_len, y_len, start_addr, color, wr_ready,
    output wr_en, wr_addr, wr_data, busy, done
  );

  modport master (
    output start, abort, x_len, y_len, start_addr, color, wr_ready,
    input  wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/trail_rect_writer_walker.sv
// rect_addr_walker: column/row counters and row base accumulator for the
// rectangle writer. It exposes flags for the current pixel and the address and
// range of the pixel that will be current after the next clock edge. That
// lookahead lets the top register its outputs without adding a cycle.
//   load_i     : latch dimensions and start address, restart at (0,0)
//   clear_i    : return all state to zero
//   advance_i  : step to the next pixel (row-major)
//   last_o     : current pixel is the final one of the rectangle
//   oor_o      : current pixel lies past the end of the frame
//   addr_nxt_o / oor_nxt_o : address and range flag after this edge
module rect_addr_walker
  import trail_rect_writer_pkg::*;
#(
  parameter int unsigned P_SCREEN_W = SCREEN_W,
  parameter int unsigned P_MAX_ADDR = MAX_ADDR,
  parameter int unsigned P_ADDR_W   = ADDR_W,
  parameter int unsigned P_DIM_W    = DIM_W
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                load_i,
  input  logic                clear_i,
  input  logic                advance_i,
  input  logic [P_DIM_W-1:0]  x_len_i,
  input  logic [P_DIM_W-1:0]  y_len_i,
  input  logic [P_ADDR_W-1:0] start_addr_i,
  output logic [P_ADDR_W-1:0] addr_nxt_o,
  output logic                last_o,
  output logic                oor_o,
  output logic                oor_nxt_o
);
  // Two spare bits: the worst case start + 1023 rows of stride + 1023 columns
  // cannot wrap. A wrap would turn an off-screen pixel back into a valid one.
  localparam int unsigned EXT_W = P_ADDR_W + 2;

  logic [P_DIM_W-1:0] col_q, col_d, row_q, row_d;
  logic [P_DIM_W-1:0] x_len_q, x_len_d, y_len_q, y_len_d;
  logic [EXT_W-1:0]   row_base_q, row_base_d;
  logic [EXT_W-1:0]   addr_cur_s, addr_nxt_s;
  logic               end_of_row_s;

  assign end_of_row_s = (col_q == x_len_q - P_DIM_W'(1));
  assign last_o       = end_of_row_s && (row_q == y_len_q - P_DIM_W'(1));
  assign addr_cur_s   = row_base_q + EXT_W'(col_q);
  assign addr_nxt_s   = row_base_d + EXT_W'(col_d);
  assign addr_nxt_o   = addr_nxt_s[P_ADDR_W-1:0];
  assign oor_o        = ~addr_in_range(32'(addr_cur_s), 32'(P_MAX_ADDR));
  assign oor_nxt_o    = ~addr_in_range(32'(addr_nxt_s), 32'(P_MAX_ADDR));

  // Next-state logic for the counters: load, clear, advance or hold.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    x_len_d    = x_len_q;
    y_len_d    = y_len_q;
    if (load_i) begin
      col_d      = '0;
      row_d      = '0;
      row_base_d = EXT_W'(start_addr_i);
      x_len_d    = x_len_i;
      y_len_d    = y_len_i;
    end else if (clear_i) begin
      col_d      = '0;
      row_d      = '0;
      row_base_d = '0;
      x_len_d    = '0;
      y_len_d    = '0;
    end else if (advance_i) begin
      if (end_of_row_s) begin
        col_d      = '0;
        row_d      = row_q + P_DIM_W'(1);
        row_base_d = row_base_q + EXT_W'(P_SCREEN_W);
      end else begin
        col_d      = col_q + P_DIM_W'(1);
      end
    end else begin
      col_d      = col_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      x_len_q    <= '0;
      y_len_q    <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      x_len_q    <= x_len_d;
      y_len_q    <= y_len_d;
    end
  end
endmodule

// File: rtl/trail_rect_writer.sv
// trail_rect_writer: fills a solid rectangle of trail pixels in the 640x480
// trail memory, one write per pixel, row by row, through a ready/enable port.
//   clock, resetn : system clock, async active-low reset
//   bus.start/abort/x_len/y_len/start_addr/color : request from game FSM
//   bus.wr_ready  : arbiter grant for the pending write
//   bus.wr_en/wr_addr/wr_data : registered memory write request
//   bus.busy/done : registered status, done is a one-cycle pulse
module trail_rect_writer
  import trail_rect_writer_pkg::*;
#(
  parameter int unsigned P_SCREEN_W = SCREEN_W,
  parameter int unsigned P_MAX_ADDR = MAX_ADDR,
  parameter int unsigned P_ADDR_W   = ADDR_W,
  parameter int unsigned P_DIM_W    = DIM_W,
  parameter int unsigned P_DATA_W   = DATA_W
) (
  input  logic                clock,
  input  logic                resetn,
  trail_rect_writer_if.slave  bus
);
  wr_state_e           state_q, state_d;
  logic                wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
  logic [P_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [P_DATA_W-1:0] wr_data_q, wr_data_d;
  logic                load_s, clear_s, advance_s;
  logic                last_s, oor_s, oor_nxt_s;
  logic [P_ADDR_W-1:0] addr_nxt_s;

  rect_addr_walker #(
    .P_SCREEN_W (P_SCREEN_W),
    .P_MAX_ADDR (P_MAX_ADDR),
    .P_ADDR_W   (P_ADDR_W),
    .P_DIM_W    (P_DIM_W)
  ) u_walker (
    .clock        (clock),
    .resetn       (resetn),
    .load_i       (load_s),
    .clear_i      (clear_s),
    .advance_i    (advance_s),
    .x_len_i      (bus.x_len),
    .y_len_i      (bus.y_len),
    .start_addr_i (bus.start_addr),
    .addr_nxt_o   (addr_nxt_s),
    .last_o       (last_s),
    .oor_o        (oor_s),
    .oor_nxt_o    (oor_nxt_s)
  );

  // FSM next state and walker control; abort outranks start.
  always_comb begin
    state_d   = state_q;
    load_s    = 1'b0;
    clear_s   = 1'b0;
    advance_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.start) begin
          load_s = 1'b1;
          if ((bus.x_len == P_DIM_W'(0)) || (bus.y_len == P_DIM_W'(0))) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          clear_s = 1'b1;
        end else begin
          // Off-frame pixels are skipped after one cycle. In-frame pixels wait for the grant.
          advance_s = oor_s | (wr_en_q & bus.wr_ready);
          if (advance_s && last_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        clear_s = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        clear_s = 1'b1;
      end
    endcase
  end

  // Output next values: derived from next state and the walker lookahead so that
  // the registered outputs describe the pixel that is current in the next cycle.
  always_comb begin
    busy_d  = (state_d == ST_WRITE);
    done_d  = (state_d == ST_DONE);
    wr_en_d = (state_d == ST_WRITE) && !oor_nxt_s;
    if (wr_en_d) begin
      wr_addr_d = addr_nxt_s;
    end else begin
      wr_addr_d = wr_addr_q;
    end
    if (load_s) begin
      wr_data_d = bus.color;
    end else begin
      wr_data_d = wr_data_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
